// File: rtl/matrix_processor_pkg.sv
// matrix_processor_pkg
// Shared types and constants for the matrix processor controller:
// FSM state encoding, matrix/vector geometry and a row-boundary helper.
package matrix_processor_pkg;

    localparam int unsigned MATRIX_ELEMS = 16;
    localparam int unsigned VECTOR_ELEMS = 4;
    localparam int unsigned ROWS         = 4;
    localparam int unsigned ROW_LEN      = MATRIX_ELEMS / ROWS;
    localparam int unsigned IDX_W        = 4;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        LDM,
        CHK,
        LDV,
        WAITV,
        MAC,
        DRAIN,
        FINISH
    } state_e;

    // True on the MAC step that completes a result row.
    function automatic logic is_row_end(input logic [IDX_W-1:0] idx);
        return (idx % IDX_W'(ROW_LEN)) == IDX_W'(ROW_LEN - 1);
    endfunction

endpackage

// File: rtl/matrix_processor_write_timer.sv
// matrix_processor_write_timer
// Delays each row-complete strobe by LATENCY cycles so the write strobe
// lines up with the accumulator result leaving the FMA pipeline.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   strobe_i       row complete on this MAC step
//   wr_en_o        delayed write strobe
//   flush_empty_o  no strobe is in flight
module matrix_processor_write_timer #(
    parameter int unsigned LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_i,
    output logic wr_en_o,
    output logic flush_empty_o
);

    logic [LATENCY-1:0] sr_q;
    logic [LATENCY-1:0] sr_d;

    // Shift towards the MSB; truncation drops the oldest bit.
    always_comb begin
        sr_d = LATENCY'({sr_q, strobe_i});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign wr_en_o       = sr_q[LATENCY-1];
    assign flush_empty_o = (sr_q == '0);

endmodule

// File: rtl/matrix_processor_controller.sv
// matrix_processor_controller
// Sequencing FSM for the matrix processor datapath: loads the 4x4 matrix
// once, then per work item loads a 4-element vector, runs 16 FMA steps and
// issues 4 result write strobes. Reads go through a req/gnt handshake.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 launch pulse (honoured only in IDLE)
//   busy, done            host status; done pulses on return to IDLE
//   memReadReq/Gnt        shared read port handshake
//   workItemCountZero     datapath work-item register is zero
//   matrixRegValue        datapath element index register
//   wiSource, wiInit      work-item register enable / load select
//   resetMatrixReg, matrixRegIncrument   element index control
//   load, loadMatrix, loadVector, readAddrSrc   read beat steering
//   enFMA, controllerWriteEn                    compute and write strobes
// Optional: define MATRIX_CTRL_PERF_EN to add perfBusyCycles and
// perfStallCycles saturating 32-bit counters.
module matrix_processor_controller
    import matrix_processor_pkg::*;
#(
    parameter int unsigned FMA_LATENCY = 1,
    parameter int unsigned WI_WIDTH    = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             memReadReq,
    input  logic             memReadGnt,
    input  logic             workItemCountZero,
    input  logic [IDX_W-1:0] matrixRegValue,
    output logic             wiSource,
    output logic             wiInit,
    output logic             resetMatrixReg,
    output logic             matrixRegIncrument,
    output logic             load,
    output logic             loadMatrix,
    output logic             loadVector,
    output logic             readAddrSrc,
    output logic             enFMA,
    output logic             controllerWriteEn
`ifdef MATRIX_CTRL_PERF_EN
    ,
    output logic [31:0]      perfBusyCycles,
    output logic [31:0]      perfStallCycles
`endif
);

    localparam int unsigned DRAIN_W = $clog2(FMA_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_M = IDX_W'(MATRIX_ELEMS - 1);
    localparam logic [IDX_W-1:0] LAST_V = IDX_W'(VECTOR_ELEMS - 1);

    if (FMA_LATENCY < 1 || FMA_LATENCY > 4) begin : g_bad_latency
        $error("FMA_LATENCY must be 1..4");
    end
    if (WI_WIDTH < 1) begin : g_bad_wi_width
        $error("WI_WIDTH must be at least 1");
    end

    state_e               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                 done_q, done_d;
    logic                 row_strobe;
    logic                 flush_empty;

    // State, drain counter and done pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d            = state_q;
        drain_cnt_d        = '0;
        done_d             = 1'b0;
        row_strobe         = 1'b0;
        memReadReq         = 1'b0;
        wiSource           = 1'b0;
        wiInit             = 1'b0;
        resetMatrixReg     = 1'b0;
        matrixRegIncrument = 1'b0;
        load               = 1'b0;
        loadMatrix         = 1'b0;
        loadVector         = 1'b0;
        readAddrSrc        = 1'b0;
        enFMA              = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                wiSource       = 1'b1;
                wiInit         = 1'b1;
                resetMatrixReg = 1'b1;
                state_d        = LDM;
            end
            LDM: begin
                memReadReq = 1'b1;
                if (memReadGnt) begin
                    load               = 1'b1;
                    loadMatrix         = 1'b1;
                    matrixRegIncrument = 1'b1;
                    if (matrixRegValue == LAST_M) begin
                        resetMatrixReg = 1'b1;
                        state_d        = CHK;
                    end
                end
            end
            CHK: begin
                if (workItemCountZero) begin
                    state_d = FINISH;
                end else begin
                    wiSource = 1'b1;
                    state_d  = LDV;
                end
            end
            LDV: begin
                memReadReq  = 1'b1;
                readAddrSrc = 1'b1;
                if (memReadGnt) begin
                    load               = 1'b1;
                    loadVector         = 1'b1;
                    matrixRegIncrument = 1'b1;
                    if (matrixRegValue == LAST_V) begin
                        resetMatrixReg = 1'b1;
                        state_d        = WAITV;
                    end
                end
            end
            WAITV: begin
                state_d = MAC;
            end
            MAC: begin
                enFMA              = 1'b1;
                matrixRegIncrument = 1'b1;
                row_strobe         = is_row_end(matrixRegValue);
                if (matrixRegValue == LAST_M) begin
                    resetMatrixReg = 1'b1;
                    state_d        = DRAIN;
                end
            end
            DRAIN: begin
                // FMA_LATENCY flush cycles with enFMA, then one idle cycle.
                enFMA = (drain_cnt_q < DRAIN_W'(FMA_LATENCY));
                if (drain_cnt_q != DRAIN_W'(FMA_LATENCY)) begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end else begin
                    drain_cnt_d = drain_cnt_q;
                    if (flush_empty) begin
                        state_d = workItemCountZero ? FINISH : CHK;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

    matrix_processor_write_timer #(
        .LATENCY (FMA_LATENCY)
    ) u_write_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .strobe_i      (row_strobe),
        .wr_en_o       (controllerWriteEn),
        .flush_empty_o (flush_empty)
    );

`ifdef MATRIX_CTRL_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating activity counters, cleared by an accepted start.
    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (state_q == IDLE && start) begin
            perf_busy_d  = '0;
            perf_stall_d = '0;
        end else begin
            if (busy && perf_busy_q != '1) begin
                perf_busy_d = perf_busy_q + 32'd1;
            end
            if (memReadReq && !memReadGnt && perf_stall_q != '1) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perfBusyCycles  = perf_busy_q;
    assign perfStallCycles = perf_stall_q;
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_matrix_processor_controller.sv
// tb_matrix_processor_controller
// Directed bench: models the datapath work-item and element-index
// registers, drives grant patterns and checks beat counts, strobe timing
// and done latency against hand-computed values.
module tb_matrix_processor_controller;

    localparam int unsigned LAT = 2;
    localparam int unsigned WIW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        memReadGnt = 1'b1;
    logic        workItemCountZero;
    logic [3:0]  matrixRegValue;
    logic        busy, done, memReadReq, wiSource, wiInit, resetMatrixReg;
    logic        matrixRegIncrument, load, loadMatrix, loadVector, readAddrSrc;
    logic        enFMA, controllerWriteEn;
`ifdef MATRIX_CTRL_PERF_EN
    logic [31:0] perfBusyCycles, perfStallCycles;
`endif

    matrix_processor_controller #(
        .FMA_LATENCY (LAT),
        .WI_WIDTH    (WIW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .busy               (busy),
        .done               (done),
        .memReadReq         (memReadReq),
        .memReadGnt         (memReadGnt),
        .workItemCountZero  (workItemCountZero),
        .matrixRegValue     (matrixRegValue),
        .wiSource           (wiSource),
        .wiInit             (wiInit),
        .resetMatrixReg     (resetMatrixReg),
        .matrixRegIncrument (matrixRegIncrument),
        .load               (load),
        .loadMatrix         (loadMatrix),
        .loadVector         (loadVector),
        .readAddrSrc        (readAddrSrc),
        .enFMA              (enFMA),
        .controllerWriteEn  (controllerWriteEn)
`ifdef MATRIX_CTRL_PERF_EN
        ,
        .perfBusyCycles     (perfBusyCycles),
        .perfStallCycles    (perfStallCycles)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Datapath register model.
    logic [WIW-1:0] wi_reg;
    logic [3:0]     mreg;
    logic [WIW-1:0] wi_cfg = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            wi_reg <= '0;
            mreg   <= '0;
        end else begin
            if (resetMatrixReg)          mreg <= 4'd0;
            else if (matrixRegIncrument) mreg <= mreg + 4'd1;
            if (wiSource) wi_reg <= wiInit ? wi_cfg : wi_reg - WIW'(1);
        end
    end
    assign workItemCountZero = (wi_reg == '0);
    assign matrixRegValue    = mreg;

    // Grant driver: 0 = always granted, 1 = toggling, 2 = first stall_cfg requests refused.
    int   gnt_mode  = 0;
    int   stall_cfg = 0;
    logic clr_req   = 1'b0;
    int   stall_used = 0;

    always @(posedge clk) begin
        #1;
        if (clr_req) stall_used = 0;
        case (gnt_mode)
            0: memReadGnt = 1'b1;
            1: memReadGnt = ~memReadGnt;
            default: begin
                if (memReadReq && stall_used < stall_cfg) begin
                    memReadGnt = 1'b0;
                    stall_used++;
                end else begin
                    memReadGnt = 1'b1;
                end
            end
        endcase
    end

    // Monitor, sampled mid-cycle.
    int cyc = 0;
    int lm, lv, ld, fma, we, dn, viol, we_err, busy_cnt;
    int start_cyc, done_cyc;
    int lv_idx [8];
    bit pipe [LAT];

    always @(negedge clk) begin
        cyc++;
        if (clr_req || !rst_n) begin
            lm = 0; lv = 0; ld = 0; fma = 0; we = 0; dn = 0;
            viol = 0; we_err = 0; busy_cnt = 0;
            start_cyc = -1; done_cyc = -1;
            for (int i = 0; i < 8; i++) lv_idx[i] = 0;
            for (int i = 0; i < int'(LAT); i++) pipe[i] = 1'b0;
        end else begin
            if (loadMatrix) lm++;
            if (loadVector) begin
                lv++;
                lv_idx[wi_reg[2:0]]++;
            end
            if (load)              ld++;
            if (enFMA)             fma++;
            if (controllerWriteEn) we++;
            if (busy)              busy_cnt++;
            if (done) begin
                dn++;
                if (done_cyc < 0) done_cyc = cyc;
                if (busy) viol++;
            end
            if (start && start_cyc < 0) start_cyc = cyc;
            if ((load || loadMatrix || loadVector) && enFMA) viol++;
            if (load != (memReadReq && memReadGnt)) viol++;
            if (loadMatrix && loadVector) viol++;
            // Row r completes at MAC step 4r+3; strobe expected LAT cycles later.
            if (controllerWriteEn != pipe[LAT-1]) we_err++;
            for (int i = int'(LAT) - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = enFMA && (mreg[1:0] == 2'd3);
        end
    end

    task automatic clear_stats();
        clr_req = 1'b1;
        @(posedge clk); #2;
        clr_req = 1'b0;
    endtask

    // Launch one run and wait (bounded) for done; optional stray start in LDV.
    task automatic run(input int n, input int mode, input int stall, input bit pulse_ldv, input string tag);
        bit pulsed = 1'b0;
        wi_cfg    = WIW'(n);
        gnt_mode  = mode;
        stall_cfg = stall;
        clear_stats();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (pulse_ldv && !pulsed && memReadReq && readAddrSrc) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (dn > 0) break;
        end
        start = 1'b0;
        check_eq({tag, "_finished"}, 32'(dn > 0), 32'd1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    function automatic int exp_done_off(input int n, input int stall);
        return (n == 0) ? 20 + stall : 19 + n * (23 + int'(LAT)) + stall;
    endfunction

    logic [12:0] outs;
    assign outs = {busy, done, memReadReq, wiSource, wiInit, resetMatrixReg, matrixRegIncrument,
                   load, loadMatrix, loadVector, readAddrSrc, enFMA, controllerWriteEn};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_outputs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Zero work items.
        run(0, 0, 0, 1'b0, "n0");
        check_eq("n0_matrix_beats", lm, 16);
        check_eq("n0_vector_beats", lv, 0);
        check_eq("n0_writes", we, 0);
        check_eq("n0_fma", fma, 0);
        check_eq("n0_done_latency", done_cyc - start_cyc, exp_done_off(0, 0));
        check_eq("n0_done_pulses", dn, 1);
        check_eq("n0_violations", viol, 0);

        // One work item.
        run(1, 0, 0, 1'b0, "n1");
        check_eq("n1_matrix_beats", lm, 16);
        check_eq("n1_vector_beats", lv, 4);
        check_eq("n1_fma", fma, 16 + int'(LAT));
        check_eq("n1_writes", we, 4);
        check_eq("n1_write_timing", we_err, 0);
        check_eq("n1_done_latency", done_cyc - start_cyc, exp_done_off(1, 0));
        check_eq("n1_done_pulses", dn, 1);
        check_eq("n1_violations", viol, 0);

        // Three work items, toggling grant.
        run(3, 1, 0, 1'b0, "n3");
        check_eq("n3_matrix_beats", lm, 16);
        check_eq("n3_vector_beats", lv, 12);
        check_eq("n3_idx2_beats", lv_idx[2], 4);
        check_eq("n3_idx1_beats", lv_idx[1], 4);
        check_eq("n3_idx0_beats", lv_idx[0], 4);
        check_eq("n3_load_total", ld, 28);
        check_eq("n3_writes", we, 12);
        check_eq("n3_write_timing", we_err, 0);
        check_eq("n3_fma", fma, 3 * (16 + int'(LAT)));
        check_eq("n3_done_pulses", dn, 1);
        check_eq("n3_violations", viol, 0);

        // Reset in the MAC phase of the second item.
        wi_cfg   = WIW'(3);
        gnt_mode = 0;
        clear_stats();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk); #2;
                if (lv >= 8 && enFMA) begin
                    hit = 1'b1;
                    break;
                end
            end
            check_eq("rst_reached_mac2", 32'(hit), 32'd1);
        end
        rst_n = 1'b0;
        @(posedge clk); #2;
        check_eq("rst_mid_outputs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        clear_stats();
        repeat (60) @(posedge clk);
        #2;
        check_eq("rst_no_done", dn, 0);
        check_eq("rst_no_writes", we, 0);
        check_eq("rst_no_loads", ld, 0);
        check_eq("rst_idle_outputs", 32'(outs), 32'd0);
        run(1, 0, 0, 1'b0, "rst_rerun");
        check_eq("rerun_writes", we, 4);
        check_eq("rerun_done_latency", done_cyc - start_cyc, exp_done_off(1, 0));

        // Stray start in LDV is ignored.
        run(1, 0, 0, 1'b1, "pulse");
        check_eq("pulse_vector_beats", lv, 4);
        check_eq("pulse_writes", we, 4);
        check_eq("pulse_done_latency", done_cyc - start_cyc, exp_done_off(1, 0));
        check_eq("pulse_done_pulses", dn, 1);
        check_eq("pulse_violations", viol, 0);

        // First request stalled for 5 cycles.
        run(1, 2, 5, 1'b0, "stall");
        check_eq("stall_matrix_beats", lm, 16);
        check_eq("stall_done_latency", done_cyc - start_cyc, exp_done_off(1, 5));
        check_eq("stall_writes", we, 4);
`ifdef MATRIX_CTRL_PERF_EN
        check_eq("perf_stall", perfStallCycles, 32'd5);
        check_eq("perf_busy", perfBusyCycles, 32'(busy_cnt));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
